mem_read_ctrl: RTL



---
 rtl/mem_ctrl_pkg.sv | 14 +
 rtl/mem_read_ctrl_if.sv | 13 +
 rtl/read_timeout_counter.sv | 28 ++
 rtl/mem_read_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and default sizes for the memory-read controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 9;
    localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/mem_read_ctrl_if.sv
// Memory-side read bus: the controller is the master, the memory model/array the slave.
interface mem_read_ctrl_if #(
    parameter int ADDR_W = mem_ctrl_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_ctrl_pkg::DATA_W_DEF
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;

    modport master (output mem_addr, output mem_rd, input mem_ack, input mem_data);
    modport slave  (input mem_addr, input mem_rd, output mem_ack, output mem_data);
endinterface

// File: rtl/read_timeout_counter.sv
// Counts WAIT cycles without ack; tc marks the TERM-th such cycle, so the
// controller gives up on the edge that closes it.
module read_timeout_counter #(
    parameter int TERM = mem_ctrl_pkg::TIMEOUT_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TERM + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == CW'(TERM - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (restart)        cnt_d = '0;
        else if (en && !tc) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_read_ctrl.sv
// Memory-read controller: latch address on start, hold mem_rd until ack, capture word into Q.
// Optional WAIT timeout with sticky err is compiled in by defining MEM_READ_TIMEOUT_EN.
module mem_read_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_in,
    mem_read_ctrl_if.master   mem,
    output logic [DATA_W-1:0] Q,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              err_q, err_d;
    logic              tmo;

`ifdef MEM_READ_TIMEOUT_EN
    // Any start seen outside WAIT is accepted and begins a fresh WAIT window.
    read_timeout_counter #(.TERM(TIMEOUT)) u_tmo (
        .clk     (clk),
        .clr     (clr),
        .restart (start && (state_q != S_WAIT)),
        .en      ((state_q == S_WAIT) && !mem.mem_ack),
        .tc      (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        q_d     = q_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = addr_in;
                    err_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // ack wins over a coincident timeout
                if (mem.mem_ack) begin
                    q_d     = mem.mem_data;
                    state_d = S_DONE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    addr_d  = addr_in;
                    err_d   = 1'b0;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            q_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            q_q     <= q_d;
            err_q   <= err_d;
        end
    end

    // Outputs are straight from registers or state decode.
    assign mem.mem_addr = addr_q;
    assign mem.mem_rd   = (state_q == S_WAIT);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign Q            = q_q;
    assign err          = err_q;
endmodule
